// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: state encoding for the skid stage register.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

    // Encoding equals occupancy so the stage can drive its count straight from state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with optional two-entry skid buffer between stages.
// Latency: one cycle from acceptance into an empty stage to out_valid.
// Backpressure: SKID=1 gives registered in_ready (low only when FULL); SKID=0 gives
//   in_ready = !out_valid || out_ready combinationally.
// Ports: CLK/nRST (async active-low), flush discards held beats, in_* upstream
//   valid/ready/payload, out_* downstream valid/ready/payload, count = occupancy 0..2.
module pipe_skid_reg
    import cpu_types_pkg::*;
#(
    parameter int unsigned      WIDTH  = 32,
    parameter int unsigned      SKID   = 1,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    skid_state_t      state, state_n;
    logic [WIDTH-1:0] main_q, main_n;
    logic [WIDTH-1:0] skid_q, skid_n;
    logic             acc;
    logic             take;

    assign acc       = in_valid && in_ready;
    assign take      = out_valid && out_ready;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign count     = state;

    generate
        if (SKID != 0) begin : g_skid
            // Registered ready: the skid entry absorbs the beat that arrives in the
            // cycle downstream stalls, so out_ready never reaches in_ready.
            assign in_ready = (state != FULL);

            always_comb begin
                state_n = state;
                main_n  = main_q;
                skid_n  = skid_q;
                case (state)
                    EMPTY: begin
                        if (acc) begin
                            state_n = ONE;
                            main_n  = in_data;
                        end
                    end
                    ONE: begin
                        if (acc && take) begin
                            main_n = in_data;
                        end else if (acc) begin
                            state_n = FULL;
                            skid_n  = in_data;
                        end else if (take) begin
                            state_n = EMPTY;
                            main_n  = BUBBLE;
                        end
                    end
                    FULL: begin
                        // in_ready is low here, so only the drain case exists.
                        if (take) begin
                            state_n = ONE;
                            main_n  = skid_q;
                            skid_n  = BUBBLE;
                        end
                    end
                    default: begin
                        state_n = EMPTY;
                        main_n  = BUBBLE;
                        skid_n  = BUBBLE;
                    end
                endcase
                // Flush wins over any accept/take in the same cycle.
                if (flush) begin
                    state_n = EMPTY;
                    main_n  = BUBBLE;
                    skid_n  = BUBBLE;
                end
            end
        end else begin : g_single
            // Single entry: a beat may enter in the same cycle the held one leaves.
            assign in_ready = (state == EMPTY) || out_ready;

            always_comb begin
                state_n = state;
                main_n  = main_q;
                skid_n  = skid_q;   // unused entry, stays at BUBBLE from reset
                if (acc) begin
                    state_n = ONE;
                    main_n  = in_data;
                end else if (take) begin
                    state_n = EMPTY;
                    main_n  = BUBBLE;
                end
                if (flush) begin
                    state_n = EMPTY;
                    main_n  = BUBBLE;
                    skid_n  = BUBBLE;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= EMPTY;
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else begin
            state  <= state_n;
            main_q <= main_n;
            skid_q <= skid_n;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: a SKID=1/WIDTH=32 stage and a SKID=0/WIDTH=8 stage.
// Each stage is modelled as a bounded FIFO of expected beats (depth 2 or 1).
// Driver pushes accepted beats; a negedge monitor checks occupancy/handshake and pops transfers.
module tb_pipe_skid_reg;

    localparam logic [31:0] BUB = 32'hBBBB_0000;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0]  count;
    logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [7:0]  in_data0, out_data0;
    logic [1:0]  count0;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  q0[$];
    int          pre_sz = 0;
    int          pre0 = 0;
    int          n_acc = 0;
    int          cyc = 0;
    bit          idle0 = 1'b0;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_dat = '0;

    always #5 CLK = ~CLK;

    pipe_skid_reg #(.WIDTH(32), .SKID(1), .BUBBLE(BUB)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    pipe_skid_reg #(.WIDTH(8), .SKID(0)) dut0 (
        .CLK(CLK), .nRST(nRST), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .count(count0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus for both stages; model acceptance comes from model occupancy.
    task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic f);
        @(posedge CLK);
        #1;
        pre_sz    = exp_q.size();
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        if (v && pre_sz < 2) begin
            n_acc++;
            if (!f) exp_q.push_back(d);
        end
        pre0       = q0.size();
        in_valid0  = !idle0 && ($urandom_range(0, 3) != 0);
        in_data0   = 8'($urandom);
        out_ready0 = ((cyc % 2) == 0);
        flush0     = !idle0 && ($urandom_range(0, 15) == 0);
        if (in_valid0 && (pre0 == 0 || out_ready0) && !flush0) q0.push_back(in_data0);
        cyc++;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0; flush0 = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_data"}, out_data, BUB);
        chk({tag, "_out_valid0"}, 32'(out_valid0), 32'd0);
        chk({tag, "_count0"}, 32'(count0), 32'd0);
        chk({tag, "_in_ready0"}, 32'(in_ready0), 32'd1);
    endtask

    // Monitor: observe the cycle's handshake just before the rising edge that commits it.
    always @(negedge CLK) begin
        if (nRST) begin
            chk("count", 32'(count), 32'(pre_sz));
            chk("out_valid", 32'(out_valid), 32'(pre_sz != 0));
            chk("in_ready", 32'(in_ready), 32'(pre_sz < 2));
            if (!out_valid) chk("bubble", out_data, BUB);
            if (hold_prev) chk("hold_stable", out_data, hold_dat);
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_beat: got %h required no beat", out_data);
                end else begin
                    chk("data", out_data, exp_q.pop_front());
                end
            end
            hold_prev = out_valid && !out_ready && !flush;
            hold_dat  = out_data;
            if (flush) exp_q.delete();

            chk("count0", 32'(count0), 32'(pre0));
            chk("out_valid0", 32'(out_valid0), 32'(pre0 != 0));
            chk("in_ready0", 32'(in_ready0), 32'(pre0 == 0 || out_ready0));
            if (!out_valid0) chk("bubble0", 32'(out_data0), 32'd0);
            if (out_valid0 && out_ready0 && !flush0) begin
                if (q0.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_beat0: got %h required no beat", out_data0);
                end else begin
                    chk("data0", 32'(out_data0), 32'(q0.pop_front()));
                end
            end
            if (flush0) q0.delete();
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        nRST = 1'b0;
        idle_inputs();
        @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        #2 nRST = 1'b1;

        // Single beat through an empty stage.
        cycle(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

        // Backpressure fills both entries, then drains in order.
        cycle(1'b1, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

        // Streaming at full rate.
        n_acc = 0;
        for (int i = 0; i < 100; i++) cycle(1'b1, 32'(i), 1'b1, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);
        @(negedge CLK);
        #1;
        chk("stream_accepted", 32'(n_acc), 32'd100);
        chk("stream_drained", 32'(exp_q.size()), 32'd0);

        // Flush in FULL with a beat offered, then flush in ONE with accept and take.
        cycle(1'b1, 32'h55, 1'b0, 1'b0);
        cycle(1'b1, 32'h66, 1'b0, 1'b0);
        cycle(1'b1, 32'h33, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 32'h77, 1'b0, 1'b0);
        cycle(1'b1, 32'h88, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset while FULL, between clock edges.
        cycle(1'b1, 32'hA1, 1'b0, 1'b0);
        cycle(1'b1, 32'hA2, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        idle_inputs();
        pre_sz = exp_q.size();
        pre0   = q0.size();
        #2 nRST = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        q0.delete();
        pre_sz = 0;
        pre0   = 0;
        @(posedge CLK);
        #3 nRST = 1'b1;
        cycle(1'b1, 32'h44, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0);

        // Drain both stages.
        idle0 = 1'b1;
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b0);
        @(negedge CLK);
        #1;
        chk("final_drain", 32'(exp_q.size()), 32'd0);
        chk("final_drain0", 32'(q0.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
